// File: rtl/mul_issue_ctrl_pkg.sv
// Shared types for the multiply issue path: funct3 encoding, issue FSM states
// and the helper that separates multiply ops from divide ops.
package mul_issue_ctrl_pkg;

  typedef enum logic [2:0] {
    mul    = 3'b000,
    mulh   = 3'b001,
    mulhsu = 3'b010,
    mulhu  = 3'b011,
    div    = 3'b100,
    divu   = 3'b101,
    rem    = 3'b110,
    remu   = 3'b111
  } muldiv_funct3_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE,
    DRAIN
  } mul_issue_state_t;

  function automatic logic is_mul_op(input muldiv_funct3_t f);
    logic [2:0] bits;
    bits = f;
    return !bits[2];
  endfunction

endpackage

// File: rtl/mul_result_select.sv
// Picks the architectural half of a 2*XLEN product: MUL wants the low word,
// every MULH variant wants the high word. Purely combinational.
module mul_result_select
  import mul_issue_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  muldiv_funct3_t    funct3,
  input  logic [2*XLEN-1:0] product,
  output logic [XLEN-1:0]   result
);

  assign result = (funct3 == mul) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];

endmodule

// File: rtl/mul_issue_ctrl.sv
// Issues EX multiplies to the iterative multiplier and stalls EX until the product returns.
// Latency: multiplier latency + 2 cycles (1 stall cycle on a MULDIV_REUSE_EN operand-cache hit).
// Backpressure: stall is combinational from state/req; a flushed op drains the multiplier before the next issue.
module mul_issue_ctrl
  import mul_issue_ctrl_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  muldiv_funct3_t    funct3,
  input  logic [XLEN-1:0]   rs1_data,
  input  logic [XLEN-1:0]   rs2_data,
  input  logic              flush,
  output logic              stall,
  output logic [XLEN-1:0]   result,
  output logic              result_valid,
  output logic              mul_start,
  output logic [XLEN-1:0]   mul_a,
  output logic [XLEN-1:0]   mul_b,
  output muldiv_funct3_t    mul_sign,
  input  logic [2*XLEN-1:0] mul_product,
  input  logic              mul_done,
  output logic              timeout_err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

  mul_issue_state_t state, state_nxt;
  logic             done_q;
  logic             completion;
  logic             accept;
  logic             hit;
  logic [CW-1:0]    counter;
  logic [XLEN-1:0]  sel_new;

  // A level-high done left over from the previous op must not end this one.
  assign completion = mul_done & ~done_q;
  assign accept     = req & is_mul_op(funct3) & ~flush;
  assign stall      = (req & is_mul_op(funct3) & (state != DONE)) | ((state == DRAIN) & req);

  mul_result_select #(.XLEN(XLEN)) u_sel_new (
    .funct3  (mul_sign),
    .product (mul_product),
    .result  (sel_new)
  );

`ifdef MULDIV_REUSE_EN
  logic [XLEN-1:0]   last_a;
  logic [XLEN-1:0]   last_b;
  muldiv_funct3_t    last_funct3;
  logic [2*XLEN-1:0] last_product;
  logic              cache_valid;
  logic [XLEN-1:0]   sel_hit;

  // The low word is sign-agnostic, so MUL may reuse any cached product.
  assign hit = cache_valid & (rs1_data == last_a) & (rs2_data == last_b) &
               ((funct3 == last_funct3) | (funct3 == mul));

  mul_result_select #(.XLEN(XLEN)) u_sel_hit (
    .funct3  (funct3),
    .product (last_product),
    .result  (sel_hit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      last_a       <= '0;
      last_b       <= '0;
      last_funct3  <= mul;
      last_product <= '0;
      cache_valid  <= 1'b0;
    end else if (state == BUSY && !flush && completion) begin
      last_a       <= mul_a;
      last_b       <= mul_b;
      last_funct3  <= mul_sign;
      last_product <= mul_product;
      cache_valid  <= 1'b1;
    end
  end
`else
  assign hit = 1'b0;
`endif

  always_comb begin
    state_nxt    = state;
    result_valid = 1'b0;
    case (state)
      IDLE:  if (accept) state_nxt = hit ? DONE : BUSY;
      BUSY: begin
        // Completion in the flush cycle means nothing is left to drain.
        if (flush)           state_nxt = completion ? IDLE : DRAIN;
        else if (completion) state_nxt = DONE;
      end
      DONE: begin
        state_nxt    = IDLE;
        result_valid = ~flush;
      end
      DRAIN: if (completion) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      done_q      <= 1'b0;
      mul_start   <= 1'b0;
      mul_a       <= '0;
      mul_b       <= '0;
      mul_sign    <= mul;
      result      <= '0;
      counter     <= '0;
      timeout_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      done_q    <= mul_done;
      mul_start <= (state == IDLE) & accept & ~hit;
      if (state == IDLE && accept) begin
        mul_a    <= rs1_data;
        mul_b    <= rs2_data;
        mul_sign <= funct3;
      end
      if (state == BUSY && !flush && completion) result <= sel_new;
`ifdef MULDIV_REUSE_EN
      if (state == IDLE && accept && hit) result <= sel_hit;
`endif
      if (state == BUSY) begin
        if (counter != TMO) counter <= counter + 1'b1;
        if (counter == TMO) timeout_err <= 1'b1;
      end else begin
        counter <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Directed and randomized checks of mul_issue_ctrl against an arithmetic reference
// and a behavioural iterative-multiplier model with programmable latency.
module tb_mul_issue_ctrl;
  import mul_issue_ctrl_pkg::*;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           req = 1'b0;
  muldiv_funct3_t funct3 = mul;
  logic [31:0]    rs1_data = '0;
  logic [31:0]    rs2_data = '0;
  logic           flush = 1'b0;
  logic           stall;
  logic [31:0]    result;
  logic           result_valid;
  logic           mul_start;
  logic [31:0]    mul_a;
  logic [31:0]    mul_b;
  muldiv_funct3_t mul_sign;
  logic [63:0]    mul_product;
  logic           mul_done;
  logic           timeout_err;

  int passed = 0;
  int total  = 0;

  // multiplier model state
  logic [63:0] mprod = '0;
  logic [63:0] mpend = '0;
  logic        mdone = 1'b0;
  bit          mbusy = 1'b0;
  int          mcnt  = 0;
  int          lat_cfg = 1;
  bit          hang = 1'b0;

  assign mul_product = mprod;
  assign mul_done    = mdone;

  always #5 clk = ~clk;

  mul_issue_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .funct3       (funct3),
    .rs1_data     (rs1_data),
    .rs2_data     (rs2_data),
    .flush        (flush),
    .stall        (stall),
    .result       (result),
    .result_valid (result_valid),
    .mul_start    (mul_start),
    .mul_a        (mul_a),
    .mul_b        (mul_b),
    .mul_sign     (mul_sign),
    .mul_product  (mul_product),
    .mul_done     (mul_done),
    .timeout_err  (timeout_err)
  );

  function automatic logic [63:0] mult(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    sa = (f == 3'd3) ? longint'({32'b0, a}) : longint'($signed(a));
    sb = (f == 3'd0 || f == 3'd1) ? longint'($signed(b)) : longint'({32'b0, b});
    return 64'(sa * sb);
  endfunction

  // Reference built from the unsigned product plus two's-complement corrections.
  function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] uu;
    logic [31:0] hi;
    uu = {32'b0, a} * {32'b0, b};
    hi = uu[63:32];
    case (f)
      3'd0:    return a * b;
      3'd1:    return hi - (a[31] ? b : 32'd0) - (b[31] ? a : 32'd0);
      3'd2:    return hi - (a[31] ? b : 32'd0);
      default: return hi;
    endcase
  endfunction

  // Level-style done: drops on start, rises lat cycles later and stays high.
  always @(posedge clk) begin
    if (rst) begin
      mdone <= 1'b0;
      mbusy <= 1'b0;
      mcnt  <= 0;
    end else if (mul_start) begin
      mdone <= 1'b0;
      mbusy <= 1'b1;
      mcnt  <= lat_cfg;
      mpend <= mult(mul_sign, mul_a, mul_b);
    end else if (mbusy) begin
      if (mcnt <= 1) begin
        mbusy <= 1'b0;
        if (!hang) begin
          mdone <= 1'b1;
          mprod <= mpend;
        end
      end else begin
        mcnt <= mcnt - 1;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_stall"},   64'(stall), 64'd0);
    check({tag, "_valid"},   64'(result_valid), 64'd0);
    check({tag, "_result"},  64'(result), 64'd0);
    check({tag, "_start"},   64'(mul_start), 64'd0);
    check({tag, "_a"},       64'(mul_a), 64'd0);
    check({tag, "_b"},       64'(mul_b), 64'd0);
    check({tag, "_sign"},    64'(mul_sign), 64'd0);
    check({tag, "_tmo"},     64'(timeout_err), 64'd0);
  endtask

  task automatic do_op(input muldiv_funct3_t f, input logic [31:0] a, input logic [31:0] b,
                       input int lat, input bit hit, input string tag);
    logic [31:0] exp_r;
    int starts, cyc, exp_lat;
    bit seen;
    exp_r   = ref_result(f, a, b);
    exp_lat = hit ? 1 : lat + 3;
    lat_cfg = lat;
    tick();
    req = 1'b1; funct3 = f; rs1_data = a; rs2_data = b;
    starts = 0; cyc = 0; seen = 1'b0;
    @(negedge clk);
    check({tag, "_stall_req"}, 64'(stall), 64'd1);
    while (!seen && cyc < 200) begin
      if (mul_start) starts++;
      if (result_valid) seen = 1'b1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    check({tag, "_seen"},   64'(seen), 64'd1);
    check({tag, "_lat"},    64'(cyc), 64'(exp_lat));
    check({tag, "_result"}, 64'(result), 64'(exp_r));
    check({tag, "_stall_done"}, 64'(stall), 64'd0);
    check({tag, "_starts"}, 64'(starts), hit ? 64'd0 : 64'd1);
    tick();
    req = 1'b0;
    @(negedge clk);
    check({tag, "_valid_1cyc"}, 64'(result_valid), 64'd0);
  endtask

  task automatic do_div(input muldiv_funct3_t f, input string tag);
    tick();
    req = 1'b1; funct3 = f; rs1_data = $urandom; rs2_data = $urandom;
    @(negedge clk);
    check({tag, "_stall"}, 64'(stall), 64'd0);
    check({tag, "_start"}, 64'(mul_start), 64'd0);
  endtask

  initial begin
    int cyc;
    int vcnt;
    bit seen;
    bit early;
    logic [2:0] f;
    logic [31:0] a, b;
`ifdef MULDIV_REUSE_EN
    bit reuse = 1'b1;
`else
    bit reuse = 1'b0;
`endif

    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check_reset("rst0");

    do_op(mul,    32'd7,        32'hFFFF_FFFD, 3, 1'b0, "mul7x-3");
    do_op(mulhu,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 1'b0, "mulhu_ff");
    do_op(mulh,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1'b0, "mulh_ff");
    do_op(mulhsu, 32'hFFFF_FFFF, 32'd2,         4, 1'b0, "mulhsu");

    // flush two cycles after mul_start, then a new op queued behind the drain
    lat_cfg = 6;
    tick(); req = 1'b1; funct3 = mul; rs1_data = 32'd11; rs2_data = 32'd13;
    tick();
    tick();
    tick(); flush = 1'b1; req = 1'b0;
    tick(); flush = 1'b0; req = 1'b1; funct3 = mul; rs1_data = 32'd5; rs2_data = 32'd6;
    cyc = 4; seen = 1'b0; early = 1'b0;
    @(negedge clk);
    check("drain_stall", 64'(stall), 64'd1);
    while (!seen && cyc < 200) begin
      if (result_valid) seen = 1'b1;
      else begin
        if (!stall) early = 1'b1;
        @(negedge clk);
        cyc++;
      end
    end
    check("drain_seen",   64'(seen), 64'd1);
    check("drain_lat",    64'(cyc), 64'd18);
    check("drain_nostal", 64'(early), 64'd0);
    check("drain_result", 64'(result), 64'd30);
    tick(); req = 1'b0;

    // operand reuse: MULH then MUL on identical operands
    do_op(mulh, 32'h1234_5678, 32'h9ABC_DEF0, 3, 1'b0, "reuse_mulh");
    do_op(mul,  32'h1234_5678, 32'h9ABC_DEF0, 3, reuse, "reuse_mul");

    // back-to-back divide requests are invisible to this block
    do_div(div,  "div0");
    do_div(divu, "div1");
    do_div(rem,  "div2");
    do_div(remu, "div3");
    tick(); req = 1'b0;

    for (int i = 0; i < 24; i++) begin
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      if (i % 6 == 0) a = 32'h8000_0000;
      if (i % 7 == 0) b = 32'hFFFF_FFFF;
      if (f[2]) begin
        do_div(muldiv_funct3_t'(f), $sformatf("rnd%0d_div", i));
        tick(); req = 1'b0;
      end else begin
        do_op(muldiv_funct3_t'(f), a, b, $urandom_range(1, 6), 1'b0, $sformatf("rnd%0d", i));
      end
    end

    // watchdog: multiplier never answers
    hang = 1'b1;
    lat_cfg = 2;
    tick(); req = 1'b1; funct3 = mulhu; rs1_data = 32'd3; rs2_data = 32'd4;
    vcnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (result_valid) vcnt++;
    end
    check("tmo_early", 64'(timeout_err), 64'd0);
    repeat (60) begin
      @(negedge clk);
      if (result_valid) vcnt++;
    end
    check("tmo_set",   64'(timeout_err), 64'd1);
    check("tmo_stall", 64'(stall), 64'd1);
    repeat (20) @(negedge clk);
    check("tmo_sticky", 64'(timeout_err), 64'd1);
    check("tmo_novalid", 64'(vcnt), 64'd0);

    // synchronous reset while BUSY
    tick(); rst = 1'b1; req = 1'b0;
    tick(); rst = 1'b0; hang = 1'b0;
    @(negedge clk);
    check_reset("rst_busy");

    do_op(mulhu, 32'hDEAD_BEEF, 32'h0000_0100, 2, 1'b0, "post_rst");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
